// File: rtl/rom_word_fetcher.sv
// rom_word_fetcher
// Reads a block of 32-bit words from the byte-wide ROM macro. For each word
// it issues four byte reads, packs the returned bytes and offers the word on
// a valid/ready stream.
//
// Handshake: a word transfers on any clk edge where out_valid && out_ready.
// out_valid and out_data stay stable until that edge. No new ROM read is
// issued while an accepted-pending word is held.
//
// Ports:
//   clk, rst_n             clock (also ROM clk0), async active-low reset
//   start, base_addr,      block request; base/count are captured when start
//   word_count             is accepted in IDLE
//   abort                  synchronous cancel of a block in progress
//   rom_cs, rom_addr       registered ROM cs0 / addr0
//   rom_dout               ROM dout0
//   out_valid, out_ready,  packed word stream
//   out_data
//   busy, done             block in progress / one-cycle completion pulse
//   fsm_state              current FSM state, for debug and checkers
module rom_word_fetcher #(
  parameter int ADDR_WIDTH = 10,
  parameter int CNT_WIDTH  = 8,
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [CNT_WIDTH-1:0]  word_count,
  input  logic                  abort,
  output logic                  rom_cs,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [7:0]            rom_dout,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [31:0]           out_data,
  output logic                  busy,
  output logic                  done,
  output logic [2:0]            fsm_state
);

  // EMPTY handles a zero-length request: busy and done are both high for
  // the single cycle after start is accepted.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    DRAIN = 3'd2,
    HOLD  = 3'd3,
    EMPTY = 3'd4
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0]  CNT_ONE  = CNT_WIDTH'(1);

  state_t                 state_q, state_d;
  logic [CNT_WIDTH-1:0]   words_left;
  logic [1:0]             iss_idx;
  logic [1:0]             cap_cnt;
  logic                   cs_d;
  logic [31:0]            asm_q;
  logic [31:0]            asm_next;
  logic                   last_word;

  assign fsm_state = state_q;
  assign last_word = (words_left == CNT_ONE);

  // Byte placement: big-endian shifts bytes in from the bottom so the first
  // byte ends up in [31:24]; little-endian shifts in from the top.
  always_comb begin
    if (BIG_ENDIAN) asm_next = {asm_q[23:0], rom_dout};
    else            asm_next = {rom_dout, asm_q[31:8]};
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (start) state_d = (word_count == '0) ? EMPTY : ISSUE;
      ISSUE: if (iss_idx == 2'd3) state_d = DRAIN;
      DRAIN: if (cs_d && cap_cnt == 2'd3) state_d = HOLD;
      HOLD:  if (out_ready) state_d = last_word ? IDLE : ISSUE;
      EMPTY: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort && state_q != IDLE) state_d = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rom_cs     <= 1'b0;
      rom_addr   <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      words_left <= '0;
      iss_idx    <= '0;
      cap_cnt    <= '0;
      cs_d       <= 1'b0;
      asm_q      <= '0;
    end else begin
      done <= 1'b0;
      // The ROM returns a byte one cycle after it samples cs, so the delayed
      // cs marks exactly the cycles whose rom_dout belongs to us.
      cs_d <= rom_cs;
      if (abort && state_q != IDLE) begin
        rom_cs    <= 1'b0;
        out_valid <= 1'b0;
        busy      <= 1'b0;
        cs_d      <= 1'b0;
        cap_cnt   <= '0;
        asm_q     <= '0;
      end else begin
        case (state_q)
          IDLE: begin
            if (start) begin
              busy       <= 1'b1;
              words_left <= word_count;
              cap_cnt    <= '0;
              if (word_count != '0) begin
                rom_cs   <= 1'b1;
                rom_addr <= base_addr;
                iss_idx  <= '0;
              end else begin
                done <= 1'b1;
              end
            end
          end
          ISSUE: begin
            if (iss_idx == 2'd3) begin
              rom_cs <= 1'b0;
            end else begin
              rom_addr <= rom_addr + ADDR_ONE;
              iss_idx  <= iss_idx + 2'd1;
            end
          end
          HOLD: begin
            if (out_ready) begin
              out_valid  <= 1'b0;
              words_left <= words_left - CNT_ONE;
              if (last_word) begin
                done <= 1'b1;
                busy <= 1'b0;
              end else begin
                rom_cs   <= 1'b1;
                rom_addr <= rom_addr + ADDR_ONE;
                iss_idx  <= '0;
              end
            end
          end
          EMPTY: busy <= 1'b0;
          default: ;
        endcase
        if (cs_d) begin
          asm_q   <= asm_next;
          cap_cnt <= cap_cnt + 2'd1;
          if (cap_cnt == 2'd3) begin
            out_data  <= asm_next;
            out_valid <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_rom_word_fetcher.sv
module tb_rom_word_fetcher;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, start, start_le, abort, out_ready;
  logic [9:0]  base_addr;
  logic [7:0]  word_count;

  logic        cs_be, valid_be, busy_be, done_be;
  logic [9:0]  addr_be;
  logic [7:0]  dout_be;
  logic [31:0] data_be;
  logic [2:0]  st_be;

  logic        cs_le, valid_le, busy_le, done_le;
  logic [9:0]  addr_le;
  logic [7:0]  dout_le;
  logic [31:0] data_le;
  logic [2:0]  st_le;

  rom_word_fetcher #(.ADDR_WIDTH(10), .CNT_WIDTH(8), .BIG_ENDIAN(1'b1)) dut_be (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .word_count(word_count), .abort(abort), .rom_cs(cs_be), .rom_addr(addr_be),
    .rom_dout(dout_be), .out_valid(valid_be), .out_ready(out_ready),
    .out_data(data_be), .busy(busy_be), .done(done_be), .fsm_state(st_be)
  );

  rom_word_fetcher #(.ADDR_WIDTH(10), .CNT_WIDTH(8), .BIG_ENDIAN(1'b0)) dut_le (
    .clk(clk), .rst_n(rst_n), .start(start_le), .base_addr(base_addr),
    .word_count(word_count), .abort(abort), .rom_cs(cs_le), .rom_addr(addr_le),
    .rom_dout(dout_le), .out_valid(valid_le), .out_ready(out_ready),
    .out_data(data_le), .busy(busy_le), .done(done_le), .fsm_state(st_le)
  );

  // ---------------- ROM models: sample at posedge, dout after negedge ----------------
  logic [7:0] mem [0:1023];
  logic [9:0] ra_be, ra_le;
  logic       rd_be = 1'b0, rd_le = 1'b0;

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 8'(i);
    dout_be = 8'h00;
    dout_le = 8'h00;
  end

  always @(posedge clk) begin
    rd_be <= cs_be; ra_be <= addr_be;
    rd_le <= cs_le; ra_le <= addr_le;
  end
  always @(negedge clk) begin
    if (rd_be) dout_be <= mem[ra_be];
    if (rd_le) dout_le <= mem[ra_le];
  end

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_le_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: samples just after the negedge, once inputs for the next
  // posedge have settled, and pops one expectation per handshake.
  always begin
    @(negedge clk);
    #1;
    if (rst_n && valid_be && out_ready) begin
      if (exp_q.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL be_word: unexpected word 0x%0h, none expected", data_be);
      end else check("be_word", data_be, exp_q.pop_front());
    end
    if (rst_n && valid_le && out_ready) begin
      if (exp_le_q.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL le_word: unexpected word 0x%0h, none expected", data_le);
      end else check("le_word", data_le, exp_le_q.pop_front());
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  logic [9:0] addr_log [0:7];
  logic       cs_log   [0:7];

  // Starts a block at the current negedge and follows it to done. Edge
  // indices count posedges after the accepting edge (accepting edge = 0).
  task automatic run_block(input bit le, input logic [9:0] base, input logic [7:0] cnt,
                           input int exp_done_edge, input bit repulse, input string tag);
    int first_valid;
    int done_edge;
    first_valid = -1;
    done_edge   = -1;
    for (int k = 0; k < 8; k++) begin addr_log[k] = 10'h0; cs_log[k] = 1'b0; end
    base_addr  = base;
    word_count = cnt;
    if (le) start_le = 1'b1; else start = 1'b1;
    for (int i = 1; i <= 80; i++) begin
      @(negedge clk);
      if (i == 1) begin start = 1'b0; start_le = 1'b0; end
      if (repulse && i == 3) begin start = 1'b1; base_addr = 10'h100; word_count = 8'd3; end
      if (repulse && i == 4) start = 1'b0;
      if (i <= 8) begin
        addr_log[i-1] = le ? addr_le : addr_be;
        cs_log[i-1]   = le ? cs_le : cs_be;
      end
      if (first_valid < 0 && (le ? valid_le : valid_be)) first_valid = i - 1;
      if (le ? done_le : done_be) begin done_edge = i - 1; break; end
    end
    check({tag, "_done_edge"}, 32'(done_edge), 32'(exp_done_edge));
    check({tag, "_first_valid_edge"}, 32'(first_valid), 32'd5);
    @(negedge clk);
    check({tag, "_done_one_cycle"}, 32'(le ? done_le : done_be), 32'd0);
    check({tag, "_busy_after"}, 32'(le ? busy_le : busy_be), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int bad;
    int seen;
    rst_n = 1'b0; start = 1'b0; start_le = 1'b0; abort = 1'b0; out_ready = 1'b1;
    base_addr = 10'h0; word_count = 8'h0;
    repeat (2) @(negedge clk);
    check("rst_cs",    32'(cs_be),    32'd0);
    check("rst_addr",  32'(addr_be),  32'd0);
    check("rst_valid", 32'(valid_be), 32'd0);
    check("rst_data",  data_be,       32'd0);
    check("rst_busy",  32'(busy_be),  32'd0);
    check("rst_done",  32'(done_be),  32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Two words, ready held high.
    exp_q.push_back(32'h10111213);
    exp_q.push_back(32'h14151617);
    run_block(1'b0, 10'h010, 8'd2, 12, 1'b0, "two_words");
    check("two_words_addr0", 32'(addr_log[0]), 32'h010);
    check("two_words_addr3", 32'(addr_log[3]), 32'h013);
    check("two_words_cs_drop", 32'(cs_log[4]), 32'd0);

    // Address wrap across the top of the ROM.
    exp_q.push_back(32'hFEFF0001);
    run_block(1'b0, 10'h3FE, 8'd1, 6, 1'b0, "wrap");
    check("wrap_addr0", 32'(addr_log[0]), 32'h3FE);
    check("wrap_addr1", 32'(addr_log[1]), 32'h3FF);
    check("wrap_addr2", 32'(addr_log[2]), 32'h000);
    check("wrap_addr3", 32'(addr_log[3]), 32'h001);

    // Little-endian packing.
    exp_le_q.push_back(32'h13121110);
    run_block(1'b1, 10'h010, 8'd1, 6, 1'b0, "little_endian");

    // Back-pressure: hold ready low for 20 cycles after the first word.
    out_ready = 1'b0;
    exp_q.push_back(32'h40414243);
    exp_q.push_back(32'h44454647);
    base_addr = 10'h040; word_count = 8'd2; start = 1'b1;
    seen = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (i == 1) start = 1'b0;
      if (valid_be) begin seen = 1; break; end
    end
    check("stall_first_valid", 32'(seen), 32'd1);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (data_be !== 32'h40414243 || valid_be !== 1'b1 || cs_be !== 1'b0) bad++;
    end
    check("stall_stable_cycles_bad", 32'(bad), 32'd0);
    out_ready = 1'b1;
    @(negedge clk);
    check("stall_restart_cs",    32'(cs_be),    32'd1);
    check("stall_restart_addr",  32'(addr_be),  32'h044);
    check("stall_restart_valid", 32'(valid_be), 32'd0);
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (done_be) begin seen = 1; break; end
    end
    check("stall_done_seen", 32'(seen), 32'd1);
    @(negedge clk);

    // Abort early in ISSUE: cs must drop at once.
    base_addr = 10'h030; word_count = 8'd1; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk); abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    check("abort_early_cs",   32'(cs_be),   32'd0);
    check("abort_early_busy", 32'(busy_be), 32'd0);

    // Abort on the cycle after the 2nd byte capture.
    base_addr = 10'h030; word_count = 8'd1; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    check("abort_cs",    32'(cs_be),    32'd0);
    check("abort_valid", 32'(valid_be), 32'd0);
    check("abort_busy",  32'(busy_be),  32'd0);
    check("abort_state", 32'(st_be),    32'd0);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done_be || valid_be || cs_be) bad++;
    end
    check("abort_quiet_cycles_bad", 32'(bad), 32'd0);
    exp_q.push_back(32'h20212223);
    run_block(1'b0, 10'h020, 8'd1, 6, 1'b0, "post_abort");

    // Zero-length block.
    base_addr = 10'h055; word_count = 8'd0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    check("zero_done", 32'(done_be), 32'd1);
    check("zero_busy", 32'(busy_be), 32'd1);
    check("zero_cs",   32'(cs_be),   32'd0);
    @(negedge clk);
    check("zero_done_drop", 32'(done_be), 32'd0);
    check("zero_busy_drop", 32'(busy_be), 32'd0);
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (cs_be || valid_be) bad++;
    end
    check("zero_no_rom_cycles_bad", 32'(bad), 32'd0);

    // start while busy is ignored.
    exp_q.push_back(32'h50515253);
    run_block(1'b0, 10'h050, 8'd1, 6, 1'b1, "busy_start");
    check("busy_start_addr0", 32'(addr_log[0]), 32'h050);
    check("busy_start_addr3", 32'(addr_log[3]), 32'h053);

    // Reset mid-ISSUE.
    base_addr = 10'h060; word_count = 8'd1; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_cs",    32'(cs_be),    32'd0);
    check("midrst_addr",  32'(addr_be),  32'd0);
    check("midrst_valid", 32'(valid_be), 32'd0);
    check("midrst_data",  data_be,       32'd0);
    check("midrst_busy",  32'(busy_be),  32'd0);
    check("midrst_done",  32'(done_be),  32'd0);
    check("midrst_state", 32'(st_be),    32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    exp_q.push_back(32'h70717273);
    run_block(1'b0, 10'h070, 8'd1, 6, 1'b0, "post_reset");

    repeat (5) @(negedge clk);
    check("be_queue_empty", 32'(exp_q.size()),    32'd0);
    check("le_queue_empty", 32'(exp_le_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
